// File: rtl/cpu_step_if.sv
// Bundles the button inputs, processor debug inputs and the controller outputs.
// master drives the buttons and processor signals; slave is the controller.
interface cpu_step_if #(
    parameter int NBTN = 4
);
    logic [NBTN-1:0] btn;
    logic [31:0]     pc;
    logic [31:0]     dbg_data;
    logic            bp_valid;
    logic [31:0]     bp_addr;
    logic [NBTN-1:0] btn_db;
    logic [NBTN-1:0] btn_rise;
    logic            cpu_en;
    logic            run_mode;
    logic [15:0]     step_cnt;
    logic [15:0]     led;

    modport master (
        output btn, pc, dbg_data, bp_valid, bp_addr,
        input  btn_db, btn_rise, cpu_en, run_mode, step_cnt, led
    );

    modport slave (
        input  btn, pc, dbg_data, bp_valid, bp_addr,
        output btn_db, btn_rise, cpu_en, run_mode, step_cnt, led
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run clock-enable controller with debounced buttons,
// breakpoint stop and a selectable 16-bit debug display.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_STEP | cpu_en follows debounced step presses; reset state
//   ST_RUN  | cpu_en pulses every RUN_DIV cycles until toggle or breakpoint
module cpu_step_ctrl #(
    parameter int NBTN      = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20,
    parameter int RUN_DIV   = 2
) (
    input  logic       clock,
    input  logic       CPU_RESETN,
    cpu_step_if.slave  bus
);
    typedef enum logic {ST_STEP = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam int               DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [NBTN-1:0]  sync1, sync2;
    logic [NBTN-1:0]  btn_db_q, btn_db_nxt, btn_rise_q;
    logic [CNT_W-1:0] db_cnt     [NBTN];
    logic [CNT_W-1:0] db_cnt_nxt [NBTN];

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic             bp_hit;
    logic             cpu_en_c;
    logic             run_mode;
    logic [1:0]       disp_sel;
    logic [15:0]      step_cnt;
    logic [15:0]      led;
    logic             unused_dbg;

    assign unused_dbg = ^bus.dbg_data[31:16];

    // A channel only advances its count while the synchronized level disagrees
    // with the accepted level; any agreement restarts the count.
    always_comb begin
        btn_db_nxt = btn_db_q;
        for (int i = 0; i < NBTN; i++) begin
            db_cnt_nxt[i] = '0;
            if (sync2[i] != btn_db_q[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    btn_db_nxt[i] = sync2[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1      <= '0;
            sync2      <= '0;
            btn_db_q   <= '0;
            btn_rise_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1      <= bus.btn;
            sync2      <= sync1;
            btn_db_q   <= btn_db_nxt;
            btn_rise_q <= btn_db_nxt & ~btn_db_q;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
        end
    end

    assign bp_hit = bus.bp_valid && (bus.pc == bus.bp_addr);

    // Divider is held at zero outside RUN, so every entry starts a fresh period.
    always_comb begin
        state_nxt = state;
        div_nxt   = '0;
        cpu_en_c  = 1'b0;
        case (state)
            ST_STEP: begin
                cpu_en_c = btn_rise_q[0];
                if (btn_rise_q[1]) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (div_cnt != DIV_LAST) begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
                cpu_en_c = (div_cnt == DIV_LAST) && !bp_hit;
                if (bp_hit || btn_rise_q[1]) begin
                    state_nxt = ST_STEP;
                end
            end
            default: state_nxt = ST_STEP;
        endcase
    end

    assign run_mode = (state == ST_RUN);

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state    <= ST_STEP;
            div_cnt  <= '0;
            disp_sel <= 2'd0;
            step_cnt <= 16'd0;
            led      <= 16'd0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            if (cpu_en_c) begin
                step_cnt <= step_cnt + 16'd1;
            end
            if (btn_rise_q[2]) begin
                disp_sel <= disp_sel + 2'd1;
            end
            case (disp_sel)
                2'd0:    led <= bus.pc[15:0];
                2'd1:    led <= bus.dbg_data[15:0];
                2'd2:    led <= step_cnt;
                default: led <= {run_mode, 15'b0};
            endcase
        end
    end

    assign bus.btn_db   = btn_db_q;
    assign bus.btn_rise = btn_rise_q;
    assign bus.cpu_en   = cpu_en_c;
    assign bus.run_mode = run_mode;
    assign bus.step_cnt = step_cnt;
    assign bus.led      = led;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: debounce timing, step/run/breakpoint
// behaviour, display select, step counter wrap and asynchronous reset.
module tb_cpu_step_ctrl;
    logic clock;
    logic CPU_RESETN;
    int   n_vec;
    int   n_err;
    int   exp_cnt;

    cpu_step_if #(.NBTN(4)) if0 ();
    cpu_step_if #(.NBTN(4)) if1 ();

    cpu_step_ctrl #(.NBTN(4), .DB_CYCLES(4), .CNT_W(3), .RUN_DIV(3)) u_dut (
        .clock      (clock),
        .CPU_RESETN (CPU_RESETN),
        .bus        (if0)
    );

    cpu_step_ctrl #(.NBTN(4), .DB_CYCLES(4), .CNT_W(3), .RUN_DIV(1)) u_fast (
        .clock      (clock),
        .CPU_RESETN (CPU_RESETN),
        .bus        (if1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int u, input int idx, input logic v);
        if (u == 0) if0.btn[idx] = v;
        else        if1.btn[idx] = v;
    endtask

    // Hold a button for 'hold' cycles then watch a long tail, counting edges and enables.
    task automatic press(input int u, input int idx, input int hold,
                         output int rises, output int ens);
        rises = 0;
        ens   = 0;
        set_btn(u, idx, 1'b1);
        for (int i = 1; i <= hold + 12; i++) begin
            @(negedge clock);
            rises += (u == 0) ? int'(if0.btn_rise[idx]) : int'(if1.btn_rise[idx]);
            ens   += (u == 0) ? int'(if0.cpu_en) : int'(if1.cpu_en);
            if (i == hold) set_btn(u, idx, 1'b0);
        end
    endtask

    task automatic enter_run0(input string tag);
        int k;
        k = 0;
        if0.btn[1] = 1'b1;
        while (if0.run_mode !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk(tag, if0.run_mode, 1'b1);
        if0.btn[1] = 1'b0;
    endtask

    initial begin
        int r, e, n, k, gaps;
        n_vec = 0;
        n_err = 0;
        exp_cnt = 0;
        CPU_RESETN = 1'b0;
        if0.btn = '0; if0.pc = 32'h0000_1234; if0.dbg_data = 32'h5555_BEEF;
        if0.bp_valid = 1'b0; if0.bp_addr = 32'h0;
        if1.btn = '0; if1.pc = 32'h0; if1.dbg_data = 32'h0;
        if1.bp_valid = 1'b1; if1.bp_addr = 32'h40;

        repeat (3) @(negedge clock);
        chk("rst_run_mode", if0.run_mode, 1'b0);
        chk("rst_cpu_en",   if0.cpu_en,   1'b0);
        chk("rst_step_cnt", if0.step_cnt, 16'h0);
        chk("rst_led",      if0.led,      16'h0);
        chk("rst_btn_db",   if0.btn_db,   4'h0);
        CPU_RESETN = 1'b1;
        repeat (3) @(negedge clock);
        chk("led_sel0_pc", if0.led, 16'h1234);

        // Held step press: accepted 2 sync + 4 count cycles after the edge.
        if0.btn[0] = 1'b1;
        repeat (5) @(negedge clock);
        chk("db0_cycle5", if0.btn_db[0], 1'b0);
        @(negedge clock);
        chk("db0_cycle6",   if0.btn_db[0],   1'b1);
        chk("rise0_cycle6", if0.btn_rise[0], 1'b1);
        chk("en_cycle6",    if0.cpu_en,      1'b1);
        @(negedge clock);
        chk("rise0_cycle7", if0.btn_rise[0], 1'b0);
        chk("en_cycle7",    if0.cpu_en,      1'b0);
        repeat (3) @(negedge clock);
        if0.btn[0] = 1'b0;
        repeat (12) @(negedge clock);
        exp_cnt = 1;
        chk("step_cnt_one", if0.step_cnt, 16'd1);

        // Glitch shorter than the debounce window, then exactly at the window.
        press(0, 0, 3, r, e);
        chk("glitch3_rises", r, 0);
        chk("glitch3_ens",   e, 0);
        press(0, 0, 4, r, e);
        chk("pulse4_rises", r, 1);
        chk("pulse4_ens",   e, 1);
        exp_cnt += 1;
        chk("step_cnt_two", if0.step_cnt, exp_cnt);

        // RUN: first pulse three cycles in, one per three cycles, step ignored.
        enter_run0("run_entry");
        chk("run_off0_en", if0.cpu_en, 1'b0);
        @(negedge clock);
        chk("run_off1_en", if0.cpu_en, 1'b0);
        @(negedge clock);
        chk("run_off2_en", if0.cpu_en, 1'b1);
        if0.btn[0] = 1'b1;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            n += int'(if0.cpu_en);
            if (i == 8) if0.btn[0] = 1'b0;
        end
        chk("run_30cyc_pulses", n, 10);
        if0.btn[1] = 1'b1;
        n = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            n += int'(if0.cpu_en);
        end
        chk("exit_window_pulses", n, 2);
        chk("exit_still_run", if0.run_mode, 1'b1);
        @(negedge clock);
        chk("exit_step_mode", if0.run_mode, 1'b0);
        if0.btn[1] = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            n += int'(if0.cpu_en);
        end
        chk("step_idle_pulses", n, 0);
        exp_cnt += 13;
        chk("step_cnt_after_run", if0.step_cnt, exp_cnt);

        // Breakpoint lands on a slot that would otherwise pulse.
        if0.bp_valid = 1'b1;
        if0.bp_addr  = 32'h10;
        enter_run0("bp_run_entry");
        @(negedge clock);
        @(negedge clock);
        if0.pc = 32'h10;
        #1;
        chk("bp_en_suppressed", if0.cpu_en,   1'b0);
        chk("bp_same_cycle",    if0.run_mode, 1'b1);
        @(negedge clock);
        chk("bp_to_step", if0.run_mode, 1'b0);
        if0.pc = 32'h0000_1234;
        if0.bp_valid = 1'b0;
        repeat (12) @(negedge clock);
        chk("bp_step_cnt", if0.step_cnt, exp_cnt);

        // Display select cycles pc -> dbg -> step_cnt -> mode -> pc.
        press(0, 2, 8, r, e);
        chk("led_sel1_dbg", if0.led, 16'hBEEF);
        if0.btn[2] = 1'b1;
        k = 0;
        while (if0.btn_rise[2] !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("sel2_rise_seen", if0.btn_rise[2], 1'b1);
        @(negedge clock);
        @(negedge clock);
        chk("led_sel2_cnt", if0.led, exp_cnt);
        if0.btn[2] = 1'b0;
        repeat (12) @(negedge clock);
        press(0, 2, 8, r, e);
        chk("led_sel3_mode", if0.led, 16'h0000);
        press(0, 2, 8, r, e);
        chk("led_sel_wrap_pc", if0.led, 16'h1234);

        // Continuous run at divide-by-one up to 0xFFFF, stop on breakpoint, wrap by one step.
        k = 0;
        if1.btn[1] = 1'b1;
        while (if1.run_mode !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("fast_run_entry", if1.run_mode, 1'b1);
        if1.btn[1] = 1'b0;
        k = 0;
        gaps = 0;
        if (if1.cpu_en !== 1'b1) gaps++;
        while (if1.step_cnt !== 16'hFFFF && k < 70000) begin
            @(negedge clock);
            k++;
            if (if1.cpu_en !== 1'b1) gaps++;
        end
        chk("fast_reach_ffff", if1.step_cnt, 16'hFFFF);
        chk("fast_en_gaps", gaps, 0);
        if1.pc = 32'h40;
        #1;
        chk("fast_bp_en", if1.cpu_en, 1'b0);
        @(negedge clock);
        chk("fast_bp_mode", if1.run_mode, 1'b0);
        chk("fast_hold_ffff", if1.step_cnt, 16'hFFFF);
        if1.pc = 32'h0;
        if1.bp_valid = 1'b0;
        press(1, 0, 8, r, e);
        chk("wrap_ens", e, 1);
        chk("wrap_cnt", if1.step_cnt, 16'h0000);

        // Asynchronous reset in the middle of RUN and of a step debounce.
        enter_run0("rst_run_entry");
        repeat (4) @(negedge clock);
        if0.btn[0] = 1'b1;
        @(negedge clock);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        chk("async_run_mode", if0.run_mode, 1'b0);
        chk("async_cpu_en",   if0.cpu_en,   1'b0);
        chk("async_step_cnt", if0.step_cnt, 16'h0);
        chk("async_led",      if0.led,      16'h0);
        chk("async_btn_db",   if0.btn_db,   4'h0);
        chk("async_btn_rise", if0.btn_rise, 4'h0);
        @(negedge clock);
        CPU_RESETN = 1'b1;
        repeat (5) @(negedge clock);
        chk("post_rst_db_c5", if0.btn_db[0], 1'b0);
        @(negedge clock);
        chk("post_rst_db_c6", if0.btn_db[0], 1'b1);
        if0.btn[0] = 1'b0;
        repeat (12) @(negedge clock);
        chk("post_rst_mode", if0.run_mode, 1'b0);
        chk("post_rst_cnt",  if0.step_cnt, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
